uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an internal transmit FIFO. It is the successor to the fixed-format serial output path behind `uart_s_out`. Data width, parity mode, stop-bit count, baud divisor and FIFO depth are all configurable. The processor or memory-mapped bus pushes words through a valid/ready handshake, and the block serialises them back-to-back onto the line with no CPU pacing.

---
 rtl/uart_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO. Words pushed over valid/ready are
// framed (start, data LSB first, optional parity, stop) and sent back-to-back.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_BITS-1:0]              tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              uart_s_out,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam int NW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);
  localparam logic          STOP_LAST  = (STOP_BITS == 2);
  localparam logic          ODD_PARITY = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [NW-1:0]        count;
  state_t               state;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic                 line;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 not_empty;

  assign not_empty  = (count != '0);
  assign tx_ready   = (count != FULL_COUNT);
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (baud == BAUD_LAST);
  assign head       = mem[rd_ptr];
  // A pop happens from IDLE, or on the very last stop cycle so frames abut.
  assign pop        = not_empty &&
                      ((state == IDLE) ||
                       ((state == STOP) && bit_end && (stop_idx == STOP_LAST)));
  assign busy       = (state != IDLE) || not_empty;
  assign uart_s_out = line;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      parity_bit <= 1'b0;
      line       <= 1'b1;
    end else begin
      baud <= bit_end ? '0 : baud + CW'(1);
      case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            shift      <= head;
            parity_bit <= (^head) ^ ODD_PARITY;
            line       <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            line    <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              if (PARITY != 0) begin
                line  <= parity_bit;
                state <= PAR;
              end else begin
                line     <= 1'b1;
                stop_idx <= 1'b0;
                state    <= STOP;
              end
            end else begin
              shift   <= shift >> 1;
              line    <= shift[1];
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            line     <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx == STOP_LAST) begin
              if (pop) begin
                shift      <= head;
                parity_bit <= (^head) ^ ODD_PARITY;
                line       <= 1'b0;
                state      <= START;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          line  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three differently configured instances compared every
// cycle against a frame-level reference model built from the serial framing rules.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] din [3];
  logic       vld [3];

  logic       a_line, a_ready, a_busy;
  logic [4:0] a_cnt;
  logic       b_line, b_ready, b_busy;
  logic [2:0] b_cnt;
  logic       c_line, c_ready, c_busy;
  logic [1:0] c_cnt;

  logic       line_s  [3];
  logic       ready_s [3];
  logic       busy_s  [3];
  logic [4:0] cnt_s   [3];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: word queue as a circular buffer, current frame as a bit list.
  logic [8:0]  wbuf [3][64];
  int          head [3];
  int          tail [3];
  logic [15:0] fbits [3];
  int          rem [3];
  int          tot [3];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .tx_data(din[0][7:0]), .tx_valid(vld[0]), .tx_ready(a_ready),
    .uart_s_out(a_line), .busy(a_busy), .fifo_count(a_cnt));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .tx_data(din[1][7:0]), .tx_valid(vld[1]), .tx_ready(b_ready),
    .uart_s_out(b_line), .busy(b_busy), .fifo_count(b_cnt));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)) dut_c (
    .clk(clk), .rst(rst), .tx_data(din[2][6:0]), .tx_valid(vld[2]), .tx_ready(c_ready),
    .uart_s_out(c_line), .busy(c_busy), .fifo_count(c_cnt));

  assign line_s[0] = a_line;  assign ready_s[0] = a_ready;  assign busy_s[0] = a_busy;  assign cnt_s[0] = a_cnt;
  assign line_s[1] = b_line;  assign ready_s[1] = b_ready;  assign busy_s[1] = b_busy;  assign cnt_s[1] = 5'(b_cnt);
  assign line_s[2] = c_line;  assign ready_s[2] = c_ready;  assign busy_s[2] = c_busy;  assign cnt_s[2] = 5'(c_cnt);

  function automatic int dbits(int i);
    return (i == 2) ? 7 : 8;
  endfunction
  function automatic int pmode(int i);
    return i;
  endfunction
  function automatic int sbits(int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int depth(int i);
    return (i == 0) ? 16 : ((i == 1) ? 4 : 2);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      head[i] = 0; tail[i] = 0; rem[i] = 0; tot[i] = 0; fbits[i] = '1;
    end
  endtask

  task automatic load_frame(int i, logic [8:0] w);
    logic [15:0] b;
    int nb;
    logic par;
    b = '1; nb = 0; par = 1'b0;
    b[nb] = 1'b0; nb++;
    for (int k = 0; k < dbits(i); k++) begin
      b[nb] = w[k]; par ^= w[k]; nb++;
    end
    if (pmode(i) != 0) begin
      b[nb] = (pmode(i) == 2) ? ~par : par; nb++;
    end
    for (int s = 0; s < sbits(i); s++) begin
      b[nb] = 1'b1; nb++;
    end
    fbits[i] = b;
    tot[i] = 4 * nb;
    rem[i] = 4 * nb;
  endtask

  task automatic model_edge(int i);
    int n_pre;
    n_pre = tail[i] - head[i];
    if (rem[i] > 0) rem[i]--;
    if (rem[i] == 0 && n_pre > 0) begin
      load_frame(i, wbuf[i][head[i] % 64]);
      head[i]++;
    end
    if (vld[i] && n_pre < depth(i)) begin
      wbuf[i][tail[i] % 64] = din[i];
      tail[i]++;
    end
  endtask

  task automatic check_all();
    int   ecnt;
    logic eline, eready, ebusy;
    for (int i = 0; i < 3; i++) begin
      ecnt   = tail[i] - head[i];
      eline  = (rem[i] > 0) ? fbits[i][(tot[i] - rem[i]) / 4] : 1'b1;
      eready = (ecnt < depth(i));
      ebusy  = (rem[i] > 0) || (ecnt > 0);
      vectors += 4;
      assert (line_s[i] === eline) else begin
        miscompares++;
        $error("FAIL line[%0d] t=%0t got %b want %b", i, $time, line_s[i], eline);
      end
      assert (ready_s[i] === eready) else begin
        miscompares++;
        $error("FAIL tx_ready[%0d] t=%0t got %b want %b", i, $time, ready_s[i], eready);
      end
      assert (busy_s[i] === ebusy) else begin
        miscompares++;
        $error("FAIL busy[%0d] t=%0t got %b want %b", i, $time, busy_s[i], ebusy);
      end
      assert (cnt_s[i] === 5'(ecnt)) else begin
        miscompares++;
        $error("FAIL fifo_count[%0d] t=%0t got %0d want %0d", i, $time, cnt_s[i], ecnt);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_clear();
    else for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin din[i] = '0; vld[i] = 1'b0; end
    model_clear();

    // Reset state
    run(2);
    #4 rst = 1'b0;
    run(3);

    // Single frames: 0xA5 plain, 0x07 with even and odd parity
    din[0] = 9'h0A5; din[1] = 9'h007; din[2] = 9'h007;
    for (int i = 0; i < 3; i++) vld[i] = 1'b1;
    step();
    idle_inputs();
    run(60);

    // Two 0x7F words back-to-back on the 7-bit/2-stop instance
    din[2] = 9'h07F; vld[2] = 1'b1;
    step(); step();
    idle_inputs();
    run(100);

    // Three words on consecutive cycles to every instance
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < 3; i++) begin din[i] = 9'(w * 9'h011); vld[i] = 1'b1; end
      step();
    end
    idle_inputs();
    run(160);

    // Hold valid for 20 cycles: 17 words accepted on the 16-deep instance
    for (int k = 0; k < 20; k++) begin
      din[0] = 9'($urandom); vld[0] = 1'b1;
      step();
    end
    idle_inputs();
    run(720);

    // Reset in the middle of data bit 3
    for (int i = 0; i < 3; i++) begin din[i] = 9'h0C3; vld[i] = 1'b1; end
    step();
    idle_inputs();
    run(19);
    #3 rst = 1'b1;
    #1;
    model_clear();
    check_all();
    step(); step();
    #4 rst = 1'b0;
    run(2);
    for (int i = 0; i < 3; i++) begin din[i] = 9'h05A; vld[i] = 1'b1; end
    step();
    idle_inputs();
    run(60);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 3; i++) begin
        din[i] = 9'($urandom);
        vld[i] = ($urandom_range(0, 7) == 0);
      end
      step();
    end
    idle_inputs();
    run(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
